muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read values (rs1/rs2 data) plus funct3 and the destination index.
- Produces a 32-bit result and rd tag for the register-file write port.
- Uses one shift/add-subtract datapath, one bit per cycle; start/busy/done handshake to control logic.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_signfix.sv | 32 +++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int ITER_DFLT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitude extraction (used at accept) and conditional result negation (used at FIX).
module muldiv_signfix import muldiv_pkg::*; #(
  parameter int W = 32
) (
  input  logic [2:0]     funct3_i,
  input  logic [W-1:0]   op_a_i,
  input  logic [W-1:0]   op_b_i,
  output logic [W-1:0]   mag_a_o,
  output logic [W-1:0]   mag_b_o,
  output logic           neg_res_o,
  input  logic [2*W-1:0] raw_i,
  input  logic           neg_i,
  output logic [2*W-1:0] fixed_o
);

  logic signed_a, signed_b, sa, sb;

  // MUL low word is sign-agnostic, so it runs as unsigned.
  assign signed_a = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                    (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
  assign signed_b = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);

  assign sa = signed_a & op_a_i[W-1];
  assign sb = signed_b & op_b_i[W-1];

  assign mag_a_o   = sa ? -op_a_i : op_a_i;
  assign mag_b_o   = sb ? -op_b_i : op_b_i;
  assign neg_res_o = (funct3_i == F3_REM) ? sa : (sa ^ sb);

  assign fixed_o = neg_i ? -raw_i : raw_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared shift/add-sub datapath.
// MULDIV_EARLY_OUT_EN: zero operands, divide-by-zero and signed overflow bypass CALC.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ITER = ITER_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(ITER);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d, a_q, a_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d, rdo_q, rdo_d;
  logic              neg_q, neg_d, div0_q, div0_d;
  logic [XLEN-1:0]   res_q, res_d;
`ifdef MULDIV_EARLY_OUT_EN
  logic              ovf_q, ovf_d, zero_q, zero_d, ovf_in, zero_in;
`endif

  logic [XLEN-1:0]   mag_a, mag_b, fix_res;
  logic              neg_in, div0_in, is_div_q, is_rem_q;
  logic [2*XLEN-1:0] fix_raw, fixed;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;

  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign result   = res_q;
  assign rd_out   = rdo_q;

  assign is_div_q = f3_q[2];
  assign is_rem_q = f3_q[1];
  assign div0_in  = funct3[2] && (op_b == '0);
`ifdef MULDIV_EARLY_OUT_EN
  assign ovf_in   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == INT_MIN) && (op_b == '1);
  assign zero_in  = (op_a == '0) || (op_b == '0);
`endif

  assign fix_raw = !is_div_q ? {hi_q, lo_q} : {{XLEN{1'b0}}, (is_rem_q ? hi_q : lo_q)};

  muldiv_signfix #(.W(XLEN)) u_signfix (
    .funct3_i  (funct3),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .mag_a_o   (mag_a),
    .mag_b_o   (mag_b),
    .neg_res_o (neg_in),
    .raw_i     (fix_raw),
    .neg_i     (neg_q),
    .fixed_o   (fixed)
  );

  always_comb begin
    fix_res = !is_div_q ? ((f3_q == F3_MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN])
                        : fixed[XLEN-1:0];
    // The iterative divider yields all-ones magnitude on zero divisor, which then gets
    // wrongly negated for signed DIV, so zero-divisor results are forced here.
    if (is_div_q && div0_q)
      fix_res = is_rem_q ? a_q : DIV0_Q;
`ifdef MULDIV_EARLY_OUT_EN
    else if (ovf_q)
      fix_res = is_rem_q ? '0 : INT_MIN;
    else if (zero_q)
      fix_res = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    a_d     = a_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    res_d   = res_q;
    rdo_d   = rdo_q;
`ifdef MULDIV_EARLY_OUT_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif

    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh - {1'b0, b_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          hi_d    = '0;
          // Divide: lo holds dividend then quotient. Multiply: lo holds multiplier then low product.
          lo_d    = funct3[2] ? mag_a : mag_b;
          b_d     = funct3[2] ? mag_b : mag_a;
          a_d     = op_a;
          f3_d    = funct3;
          rd_d    = rd_in;
          neg_d   = neg_in;
          div0_d  = div0_in;
`ifdef MULDIV_EARLY_OUT_EN
          ovf_d   = ovf_in;
          zero_d  = zero_in;
          if (div0_in || ovf_in || zero_in) state_d = S_FIX;
`endif
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          hi_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = fix_res;
        rdo_d   = rd_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      a_q     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= '0;
      rdo_q   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      a_q     <= a_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
`ifdef MULDIV_EARLY_OUT_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

endmodule
